sample_loader: RTL and testbench

// Writer side of the correlator sample memories: the user enters 4-bit samples on

---
 rtl/sample_loader.sv | 133 +++++++++++++
 tb/tb_sample_loader.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_loader.sv
// Debounced push-button writer for the two correlator sample banks, with registered read port.
// Commit lands DEBOUNCE_CYCLES+1 cycles after the synchronised button rises; reads return one cycle after rd_addr.
module sample_loader #(
    parameter int DATA_W          = 4,
    parameter int DEPTH           = 9,
    parameter int ADDR_W          = 4,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_sw,
    input  logic              bank_sel,
    input  logic              load_btn,
    input  logic              clear,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_a,
    output logic [DATA_W-1:0] rd_b,
    output logic [ADDR_W-1:0] count_a,
    output logic [ADDR_W-1:0] count_b,
    output logic              full_a,
    output logic              full_b,
    output logic              wr_pulse
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [ADDR_W-1:0] DEPTH_L  = ADDR_W'(DEPTH);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, DB_PRESS, COMMIT, HELD, DB_RELEASE} state_t;

    state_t             state;
    state_t             state_nxt;
    logic               btn_m;
    logic               btn_s;
    logic [CNT_W-1:0]   db_cnt;
    logic               cnt_done;
    logic               wr_a;
    logic               wr_b;
    logic [DATA_W-1:0]  mem_a [DEPTH];
    logic [DATA_W-1:0]  mem_b [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_m <= 1'b0;
            btn_s <= 1'b0;
        end else begin
            btn_m <= load_btn;
            btn_s <= btn_m;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Counter restarts whenever a debounce state is entered, so it only runs while the level holds.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            db_cnt <= '0;
        else if (state == DB_PRESS || state == DB_RELEASE)
            db_cnt <= db_cnt + CNT_W'(1);
        else
            db_cnt <= '0;
    end

    assign cnt_done = (db_cnt == CNT_LAST);

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:       if (btn_s) state_nxt = DB_PRESS;
            DB_PRESS:   if (!btn_s) state_nxt = IDLE;
                        else if (cnt_done) state_nxt = COMMIT;
            COMMIT:     state_nxt = HELD;
            HELD:       if (!btn_s) state_nxt = DB_RELEASE;
            DB_RELEASE: if (btn_s) state_nxt = HELD;
                        else if (cnt_done) state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        wr_a = 1'b0;
        wr_b = 1'b0;
        if (state == COMMIT && !clear) begin
            wr_a = !bank_sel && !full_a;
            wr_b =  bank_sel && !full_b;
        end
    end

    assign wr_pulse = wr_a | wr_b;
    assign full_a   = (count_a == DEPTH_L);
    assign full_b   = (count_b == DEPTH_L);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem_a[i] <= '0;
            count_a <= '0;
        end else if (clear) begin
            for (int i = 0; i < DEPTH; i++) mem_a[i] <= '0;
            count_a <= '0;
        end else if (wr_a) begin
            mem_a[count_a] <= data_sw;
            count_a        <= count_a + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem_b[i] <= '0;
            count_b <= '0;
        end else if (clear) begin
            for (int i = 0; i < DEPTH; i++) mem_b[i] <= '0;
            count_b <= '0;
        end else if (wr_b) begin
            mem_b[count_b] <= data_sw;
            count_b        <= count_b + ADDR_W'(1);
        end
    end

    // Reads see the array before this edge's write, so a same-address commit returns the old value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_a <= '0;
            rd_b <= '0;
        end else begin
            rd_a <= (rd_addr < DEPTH_L) ? mem_a[rd_addr] : '0;
            rd_b <= (rd_addr < DEPTH_L) ? mem_b[rd_addr] : '0;
        end
    end

endmodule

// File: tb/tb_sample_loader.sv
// Bench for sample_loader with a short debounce: directed corner cases, a vector table and random presses.
module tb_sample_loader;

    localparam int DEPTH = 9;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] data_sw;
    logic       bank_sel;
    logic       load_btn;
    logic       clear;
    logic [3:0] rd_addr;
    logic [3:0] rd_a, rd_b, count_a, count_b;
    logic       full_a, full_b, wr_pulse;

    sample_loader #(
        .DATA_W(4), .DEPTH(DEPTH), .ADDR_W(4), .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk(clk), .reset(reset), .data_sw(data_sw), .bank_sel(bank_sel),
        .load_btn(load_btn), .clear(clear), .rd_addr(rd_addr),
        .rd_a(rd_a), .rd_b(rd_b), .count_a(count_a), .count_b(count_b),
        .full_a(full_a), .full_b(full_b), .wr_pulse(wr_pulse)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int pulses = 0;
    logic [3:0] qa[$];
    logic [3:0] qb[$];

    typedef struct {
        bit         clr;
        bit         bank;
        logic [3:0] data;
        bit         exp_pulse;
        int         exp_ca;
        int         exp_cb;
    } vec_t;
    vec_t tbl[15];

    task automatic tick();
        @(posedge clk);
        #1;
        if (wr_pulse) pulses++;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int m_read(input bit b, input int addr);
        if (b) return (addr < qb.size()) ? int'(qb[addr]) : 0;
        return (addr < qa.size()) ? int'(qa[addr]) : 0;
    endfunction

    task automatic m_commit(input bit b, input logic [3:0] d);
        if (!b && qa.size() < DEPTH) qa.push_back(d);
        if (b && qb.size() < DEPTH) qb.push_back(d);
    endtask

    task automatic chk_counts(input string tag);
        chk({tag, " count_a"}, int'(count_a), qa.size());
        chk({tag, " count_b"}, int'(count_b), qb.size());
        chk({tag, " full_a"}, int'(full_a), int'(qa.size() == DEPTH));
        chk({tag, " full_b"}, int'(full_b), int'(qb.size() == DEPTH));
    endtask

    task automatic check_read(input string tag, input int a);
        rd_addr = 4'(a);
        tick();
        chk({tag, " rd_a"}, int'(rd_a), m_read(1'b0, a));
        chk({tag, " rd_b"}, int'(rd_b), m_read(1'b1, a));
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        qa.delete();
        qb.delete();
    endtask

    // Clean press: expected pulse count and latency come from the model's fullness.
    task automatic press(input bit b, input logic [3:0] d, input int hold, input string tag);
        int  p0, lat;
        bit  exp_pulse;
        exp_pulse = b ? (qb.size() < DEPTH) : (qa.size() < DEPTH);
        p0 = pulses;
        lat = -1;
        bank_sel = b;
        data_sw  = d;
        load_btn = 1'b1;
        for (int i = 1; i <= hold; i++) begin
            tick();
            if (wr_pulse && lat < 0) lat = i;
            if (lat > 0 && i > lat) begin
                data_sw  = 4'($urandom);
                bank_sel = 1'($urandom);
            end
        end
        load_btn = 1'b0;
        repeat (12) tick();
        chk({tag, " pulses"}, pulses - p0, int'(exp_pulse));
        if (exp_pulse) chk({tag, " latency"}, lat, 7);
        m_commit(b, d);
    endtask

    initial begin
        int p0;
        reset = 1'b0; data_sw = '0; bank_sel = 1'b0; load_btn = 1'b0;
        clear = 1'b0; rd_addr = '0;
        repeat (3) tick();
        chk("rst count_a", int'(count_a), 0);
        chk("rst count_b", int'(count_b), 0);
        chk("rst rd_a", int'(rd_a), 0);
        chk("rst rd_b", int'(rd_b), 0);
        chk("rst wr_pulse", int'(wr_pulse), 0);
        chk("rst full_a", int'(full_a), 0);
        reset = 1'b1;
        tick();

        // Reset asserted while the button is held after a commit.
        bank_sel = 1'b0; data_sw = 4'd9; load_btn = 1'b1;
        repeat (10) tick();
        chk("held count_a", int'(count_a), 1);
        reset = 1'b0; load_btn = 1'b0;
        #2;
        chk("midheld count_a", int'(count_a), 0);
        chk("midheld rd_a", int'(rd_a), 0);
        chk("midheld rd_b", int'(rd_b), 0);
        chk("midheld wr_pulse", int'(wr_pulse), 0);
        repeat (2) tick();
        reset = 1'b1;
        tick();

        // Clean press with a same-address read across the commit.
        p0 = pulses;
        bank_sel = 1'b0; data_sw = 4'd5; rd_addr = 4'd0; load_btn = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (i == 6) chk("t2 early pulse", int'(wr_pulse), 0);
            if (i == 7) chk("t2 pulse", int'(wr_pulse), 1);
            if (i == 8) begin
                chk("t2 old read", int'(rd_a), 0);
                chk("t2 count_a", int'(count_a), 1);
            end
            if (i == 9) chk("t2 rd_a", int'(rd_a), 5);
        end
        load_btn = 1'b0;
        repeat (12) tick();
        chk("t2 pulses", pulses - p0, 1);
        qa.push_back(4'd5);

        // Bouncing press and bouncing release.
        p0 = pulses;
        bank_sel = 1'b1; data_sw = 4'd11;
        for (int i = 0; i < 4; i++) begin load_btn = ~i[0]; tick(); end
        load_btn = 1'b1;
        repeat (12) tick();
        for (int i = 0; i < 4; i++) begin load_btn = i[0]; tick(); end
        load_btn = 1'b0;
        repeat (14) tick();
        chk("t3 pulses", pulses - p0, 1);
        qb.push_back(4'd11);
        chk_counts("t3");

        // Table: fill bank B past full, then clear and interleave A/B.
        do_clear();
        for (int i = 0; i < 10; i++)
            tbl[i] = '{1'b0, 1'b1, 4'(i + 1), (i < 9), 0, (i < 9) ? i + 1 : 9};
        tbl[10] = '{1'b1, 1'b0, 4'd3,  1'b1, 1, 0};
        tbl[11] = '{1'b0, 1'b1, 4'd12, 1'b1, 1, 1};
        tbl[12] = '{1'b0, 1'b0, 4'd6,  1'b1, 2, 1};
        tbl[13] = '{1'b0, 1'b1, 4'd13, 1'b1, 2, 2};
        tbl[14] = '{1'b0, 1'b0, 4'd15, 1'b1, 3, 2};
        for (int i = 0; i < 15; i++) begin
            if (tbl[i].clr) do_clear();
            p0 = pulses;
            press(tbl[i].bank, tbl[i].data, 10, $sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d exp pulses", i), pulses - p0, int'(tbl[i].exp_pulse));
            chk($sformatf("tbl%0d count_a", i), int'(count_a), tbl[i].exp_ca);
            chk($sformatf("tbl%0d count_b", i), int'(count_b), tbl[i].exp_cb);
            if (i == 9) begin
                chk("tbl full_b", int'(full_b), 1);
                rd_addr = 4'd8; tick();
                chk("tbl rd_b[8]", int'(rd_b), 9);
                rd_addr = 4'd9; tick();
                chk("tbl rd_b[9]", int'(rd_b), 0);
            end
        end
        rd_addr = 4'd0; tick(); chk("tbl a0", int'(rd_a), 3);  chk("tbl b0", int'(rd_b), 12);
        rd_addr = 4'd1; tick(); chk("tbl a1", int'(rd_a), 6);  chk("tbl b1", int'(rd_b), 13);
        rd_addr = 4'd2; tick(); chk("tbl a2", int'(rd_a), 15); chk("tbl b2", int'(rd_b), 0);

        // Clear held across the commit cycle.
        p0 = pulses;
        bank_sel = 1'b0; data_sw = 4'd8; load_btn = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (i == 6) clear = 1'b1;
            if (i == 7) chk("t5 wr_pulse", int'(wr_pulse), 0);
            if (i == 8) begin
                clear = 1'b0;
                chk("t5 count_a", int'(count_a), 0);
                chk("t5 count_b", int'(count_b), 0);
                chk("t5 full_b", int'(full_b), 0);
            end
        end
        load_btn = 1'b0;
        repeat (12) tick();
        chk("t5 pulses", pulses - p0, 0);
        qa.delete();
        qb.delete();
        press(1'b0, 4'd7, 10, "t5 after");
        check_read("t5 a0", 0);
        check_read("t5 a1", 1);

        // Randomised presses, clears and reads against the queue model.
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(9) == 0) begin
                do_clear();
                chk_counts("rnd clr");
            end else begin
                press(1'($urandom), 4'($urandom), $urandom_range(14, 8), "rnd");
                chk_counts("rnd");
            end
            check_read("rnd rd", $urandom_range(15));
            check_read("rnd rd2", $urandom_range(8));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
